// File: rtl/weight_buffer_ctrl_if.sv
// Weight buffer bus: transfer write stream, bank grant handshake
// and the convolution array read port.
interface weight_buffer_ctrl_if #(
  parameter int DATA_WIDTH      = 16,
  parameter int KERNEL_SIZE_MAX = 5,
  parameter int PARA_KERNEL     = 2,
  parameter int ADDR_WIDTH      = 6
);
  localparam int LW =
    KERNEL_SIZE_MAX * KERNEL_SIZE_MAX * DATA_WIDTH;
  localparam int DW = LW * PARA_KERNEL;

  logic [DW-1:0]                     weight_data;
  logic [ADDR_WIDTH*PARA_KERNEL-1:0] write_weight_data_addr;
  logic                              weight_data_done;
  logic                              rd_en;
  logic [ADDR_WIDTH-2:0]             rd_addr;
  logic [DW-1:0]                     rd_data;
  logic                              rd_valid;
  logic                              conv_start;
  logic                              conv_bank;
  logic                              conv_done;
  logic [1:0]                        bank_full;
  logic                              wr_overflow;

  modport master (
    output weight_data,
    output write_weight_data_addr,
    output weight_data_done,
    output rd_en,
    output rd_addr,
    output conv_done,
    input  rd_data,
    input  rd_valid,
    input  conv_start,
    input  conv_bank,
    input  bank_full,
    input  wr_overflow
  );

  modport slave (
    input  weight_data,
    input  write_weight_data_addr,
    input  weight_data_done,
    input  rd_en,
    input  rd_addr,
    input  conv_done,
    output rd_data,
    output rd_valid,
    output conv_start,
    output conv_bank,
    output bank_full,
    output wr_overflow
  );
endinterface

// File: rtl/weight_buffer_ctrl.sv
// Ping-pong weight RAM controller: one bank fills from the transfer
// stream while the convolution array reads the other.
module weight_buffer_ctrl #(
  parameter int DATA_WIDTH      = 16,
  parameter int KERNEL_SIZE_MAX = 5,
  parameter int PARA_KERNEL     = 2,
  parameter int ADDR_WIDTH      = 6
) (
  input logic                 clk,
  input logic                 rst,
  weight_buffer_ctrl_if.slave bus
);
  localparam int LW =
    KERNEL_SIZE_MAX * KERNEL_SIZE_MAX * DATA_WIDTH;
  localparam int DW    = LW * PARA_KERNEL;
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {
    EMPTY,
    FILLING,
    FULL,
    IN_USE
  } bank_st_e;

  bank_st_e st_q [2];
  bank_st_e st_d [2];

  logic       ptr_q;
  logic       ptr_d;
  logic       done_q;
  logic       tgt_q;
  logic       tgt_d;
  logic       ovf_q;
  logic       ovf_d;
  logic       cs_q;
  logic       cs_d;
  logic       cb_q;
  logic       cb_d;
  logic [1:0] full_q;
  logic [1:0] full_d;

  logic wr_tgt;
  logic wr_ok;
  logic fill_rise;
  logic any_use;
  logic gnt;
  logic gnt_bank;

  logic [LW-1:0] ram [PARA_KERNEL][DEPTH];
  logic [DW-1:0] rd_data_q;
  logic          rd_valid_q;

  always_comb begin
    wr_tgt    = bus.write_weight_data_addr[ADDR_WIDTH-1];
    any_use   = (st_q[0] == IN_USE) || (st_q[1] == IN_USE);
    wr_ok     = !bus.weight_data_done &&
                ((st_q[wr_tgt] == EMPTY) ||
                 (st_q[wr_tgt] == FILLING));
    fill_rise = bus.weight_data_done && !done_q;

    // pointer bank has priority; the other bank is a fallback
    gnt      = 1'b0;
    gnt_bank = ptr_q;
    if (!any_use) begin
      if (st_q[ptr_q] == FULL) begin
        gnt      = 1'b1;
        gnt_bank = ptr_q;
      end else if (st_q[~ptr_q] == FULL) begin
        gnt      = 1'b1;
        gnt_bank = ~ptr_q;
      end
    end

    for (int b = 0; b < 2; b++) begin
      st_d[b] = st_q[b];
      case (st_q[b])
        EMPTY: begin
          if (wr_ok && (wr_tgt == 1'(b)))
            st_d[b] = FILLING;
        end
        FILLING: begin
          if (fill_rise && (tgt_q == 1'(b)))
            st_d[b] = FULL;
        end
        FULL: begin
          if (gnt && (gnt_bank == 1'(b)))
            st_d[b] = IN_USE;
        end
        IN_USE: begin
          if (bus.conv_done)
            st_d[b] = EMPTY;
        end
        default: st_d[b] = EMPTY;
      endcase
      full_d[b] = (st_d[b] == FULL) ||
                  (st_d[b] == IN_USE);
    end

    tgt_d = bus.weight_data_done ? tgt_q : wr_tgt;
    ovf_d = ovf_q |
            (!bus.weight_data_done && !wr_ok);
    cs_d  = gnt;
    cb_d  = gnt ? gnt_bank : cb_q;
    ptr_d = gnt ? ~gnt_bank : ptr_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q[0] <= EMPTY;
      st_q[1] <= EMPTY;
      ptr_q   <= 1'b0;
      done_q  <= 1'b1;
      tgt_q   <= 1'b0;
      ovf_q   <= 1'b0;
      cs_q    <= 1'b0;
      cb_q    <= 1'b0;
      full_q  <= 2'b00;
    end else begin
      st_q    <= st_d;
      ptr_q   <= ptr_d;
      done_q  <= bus.weight_data_done;
      tgt_q   <= tgt_d;
      ovf_q   <= ovf_d;
      cs_q    <= cs_d;
      cb_q    <= cb_d;
      full_q  <= full_d;
    end
  end

  // RAM itself is never reset; writes are blocked while rst is low
  always_ff @(posedge clk) begin
    if (wr_ok && rst) begin
      for (int l = 0; l < PARA_KERNEL; l++) begin
        ram[l][bus.write_weight_data_addr[
          l*ADDR_WIDTH +: ADDR_WIDTH]] <=
          bus.weight_data[l*LW +: LW];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= bus.rd_en;
      if (bus.rd_en) begin
        for (int l = 0; l < PARA_KERNEL; l++) begin
          rd_data_q[l*LW +: LW] <=
            ram[l][{cb_q, bus.rd_addr}];
        end
      end
    end
  end

  assign bus.rd_data     = rd_data_q;
  assign bus.rd_valid    = rd_valid_q;
  assign bus.conv_start  = cs_q;
  assign bus.conv_bank   = cb_q;
  assign bus.bank_full   = full_q;
  assign bus.wr_overflow = ovf_q;

endmodule
